// File: rtl/opicorv32_rf_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// opicorv32_rf_pkg: register-file widths and controller FSM encoding. Rev 1.0
// ---------------------------------------------------------------------------
package opicorv32_rf_pkg;

  localparam int RF_AW = 6;
  localparam int RF_DW = 32;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    RD_WAIT = 2'd2
  } rf_state_e;

endpackage
`default_nettype wire

// File: rtl/opicorv32_rf_init_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// opicorv32_rf_init_seq: address counter for the power-up zeroing sweep. Rev 1.0
// ---------------------------------------------------------------------------
module opicorv32_rf_init_seq
  import opicorv32_rf_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [RF_AW-1:0] addr,
  output logic             last
);

  localparam logic [RF_AW-1:0] LAST_ADDR = RF_AW'(DEPTH - 1);

  logic [RF_AW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST_ADDR) ? '0 : cnt + RF_AW'(1);
    end
  end

  assign addr = cnt;
  assign last = (cnt == LAST_ADDR);

endmodule
`default_nettype wire

// File: rtl/opicorv32_rf_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// opicorv32_rf_ctrl: shares the core register file with a debug port, with
// starvation-driven core stall. RF_CTRL_INIT_EN adds the zeroing sweep. Rev 1.0
// ---------------------------------------------------------------------------
module opicorv32_rf_ctrl
  import opicorv32_rf_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int DEPTH        = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_wr,
  input  logic [RF_AW-1:0] core_wa,
  input  logic [RF_DW-1:0] core_d,
  input  logic [RF_AW-1:0] core_ra1,
  input  logic [RF_AW-1:0] core_ra2,
  input  logic             core_rd2_en,
  output logic             core_stall,
  output logic             init_busy,
  input  logic             dbg_req_valid,
  output logic             dbg_req_ready,
  input  logic             dbg_req_we,
  input  logic [RF_AW-1:0] dbg_req_addr,
  input  logic [RF_DW-1:0] dbg_req_wdata,
  output logic             dbg_rsp_valid,
  output logic [RF_DW-1:0] dbg_rsp_rdata,
  output logic             rf_wr,
  output logic [RF_AW-1:0] rf_wa,
  output logic [RF_DW-1:0] rf_d,
  output logic [RF_AW-1:0] rf_ra1,
  output logic [RF_AW-1:0] rf_ra2,
  input  logic [RF_DW-1:0] rf_q2
);

  localparam int            SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  // Debug addresses alias into the implemented entries rather than past them.
  localparam logic [RF_AW-1:0] ADDR_MASK = RF_AW'(DEPTH - 1);

`ifdef RF_CTRL_INIT_EN
  localparam rf_state_e RESET_STATE = INIT;
`else
  localparam rf_state_e RESET_STATE = IDLE;
`endif

  rf_state_e        state, state_nxt;
  logic [SW-1:0]    starve, starve_nxt;
  logic             stall_q;
  logic             wr_rsp_q;
  logic             ready_w;
  logic             dbg_wr_acc;
  logic             dbg_rd_acc;
  logic             core_wr_eff;
  logic [RF_AW-1:0] dbg_addr_m;

`ifdef RF_CTRL_INIT_EN
  logic [RF_AW-1:0] init_addr;
  logic             init_last;

  opicorv32_rf_init_seq #(
    .DEPTH (DEPTH)
  ) u_init_seq (
    .clk   (clk),
    .reset (reset),
    .en    (state == INIT),
    .addr  (init_addr),
    .last  (init_last)
  );

  assign init_busy = (state == INIT);
`else
  assign init_busy = 1'b0;
`endif

  assign core_stall  = stall_q | init_busy;
  assign dbg_addr_m  = dbg_req_addr & ADDR_MASK;
  // While stalled, debug owns both ports regardless of core strobes.
  assign ready_w     = (state == IDLE) &&
                       (stall_q || (dbg_req_we ? !core_wr : !core_rd2_en));
  assign dbg_wr_acc  = dbg_req_valid & ready_w & dbg_req_we & ~reset;
  assign dbg_rd_acc  = dbg_req_valid & ready_w & ~dbg_req_we & ~reset;
  assign core_wr_eff = core_wr & ~core_stall;
  assign rf_ra1      = core_ra1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT: begin
`ifdef RF_CTRL_INIT_EN
        if (init_last) state_nxt = IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      IDLE:    if (dbg_rd_acc) state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = IDLE;
      default: state_nxt = RESET_STATE;
    endcase
  end

  always_comb begin
    rf_wr         = 1'b0;
    rf_wa         = core_wa;
    rf_d          = core_d;
    rf_ra2        = core_ra2;
    dbg_rsp_valid = 1'b0;
    dbg_rsp_rdata = '0;
    if (state == INIT) begin
`ifdef RF_CTRL_INIT_EN
      rf_wr = 1'b1;
      rf_wa = init_addr;
      rf_d  = '0;
`endif
    end else begin
      if (dbg_wr_acc) begin
        rf_wr = 1'b1;
        rf_wa = dbg_addr_m;
        rf_d  = dbg_req_wdata;
      end else begin
        rf_wr = core_wr_eff;
      end
      if (dbg_rd_acc) rf_ra2 = dbg_addr_m;
    end
    if (state == RD_WAIT) begin
      dbg_rsp_valid = 1'b1;
      dbg_rsp_rdata = rf_q2;
    end else if (wr_rsp_q) begin
      dbg_rsp_valid = 1'b1;
    end
    if (reset) begin
      rf_wr         = 1'b0;
      dbg_rsp_valid = 1'b0;
      dbg_rsp_rdata = '0;
    end
  end

  assign dbg_req_ready = ready_w & ~reset;

  always_comb begin
    starve_nxt = starve;
    if (!dbg_req_valid || ready_w) begin
      starve_nxt = '0;
    end else if (state == IDLE && starve != LIMIT) begin
      starve_nxt = starve + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve   <= '0;
      stall_q  <= 1'b0;
      wr_rsp_q <= 1'b0;
    end else begin
      starve   <= starve_nxt;
      stall_q  <= (starve_nxt == LIMIT);
      wr_rsp_q <= dbg_wr_acc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_opicorv32_rf_ctrl.sv
`default_nettype none
// tb_opicorv32_rf_ctrl: scenario tasks with a response scoreboard and a
// behavioural register file behind the controller.
module tb_opicorv32_rf_ctrl;

`ifdef RF_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        core_wr;
  logic [5:0]  core_wa;
  logic [31:0] core_d;
  logic [5:0]  core_ra1;
  logic [5:0]  core_ra2;
  logic        core_rd2_en;
  logic        core_stall;
  logic        init_busy;
  logic        dbg_req_valid;
  logic        dbg_req_ready;
  logic        dbg_req_we;
  logic [5:0]  dbg_req_addr;
  logic [31:0] dbg_req_wdata;
  logic        dbg_rsp_valid;
  logic [31:0] dbg_rsp_rdata;
  logic        rf_wr;
  logic [5:0]  rf_wa;
  logic [31:0] rf_d;
  logic [5:0]  rf_ra1;
  logic [5:0]  rf_ra2;
  logic [31:0] rf_q2;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  opicorv32_rf_ctrl #(
    .STARVE_LIMIT (8),
    .DEPTH        (64)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .core_wr       (core_wr),
    .core_wa       (core_wa),
    .core_d        (core_d),
    .core_ra1      (core_ra1),
    .core_ra2      (core_ra2),
    .core_rd2_en   (core_rd2_en),
    .core_stall    (core_stall),
    .init_busy     (init_busy),
    .dbg_req_valid (dbg_req_valid),
    .dbg_req_ready (dbg_req_ready),
    .dbg_req_we    (dbg_req_we),
    .dbg_req_addr  (dbg_req_addr),
    .dbg_req_wdata (dbg_req_wdata),
    .dbg_rsp_valid (dbg_rsp_valid),
    .dbg_rsp_rdata (dbg_rsp_rdata),
    .rf_wr         (rf_wr),
    .rf_wa         (rf_wa),
    .rf_d          (rf_d),
    .rf_ra1        (rf_ra1),
    .rf_ra2        (rf_ra2),
    .rf_q2         (rf_q2)
  );

  // Register file: synchronous write, read data one cycle after the address.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (rf_wr) mem[rf_wa] <= rf_d;
    rf_q2 <= mem[rf_ra2];
  end

  task automatic idle_inputs();
    core_wr = 0; core_wa = '0; core_d = '0; core_ra1 = '0; core_ra2 = '0;
    core_rd2_en = 0; dbg_req_valid = 0; dbg_req_we = 0; dbg_req_addr = '0;
    dbg_req_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (rf_wr !== 1'b0) begin n_err++; $display("FAIL reset_rf_wr: got %b required 0", rf_wr); end
    n_cmp++;
    if (dbg_rsp_valid !== 1'b0 || dbg_rsp_rdata !== 32'h0) begin
      n_err++; $display("FAIL reset_rsp: got %b/%h required 0/0", dbg_rsp_valid, dbg_rsp_rdata);
    end
    n_cmp++;
    if (dbg_req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b required 0", dbg_req_ready); end
    n_cmp++;
    if (init_busy !== INIT_EN || core_stall !== INIT_EN) begin
      n_err++; $display("FAIL reset_busy: got busy=%b stall=%b required %b", init_busy, core_stall, INIT_EN);
    end
    next_cycle();
    reset = 1'b0;
  endtask

  // Checks sweep cycles 0..last; when full, also checks the exit cycle.
  task automatic sweep_check(input int last, input bit full);
    for (int n = 0; n <= last; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({rf_wr, rf_wa, rf_d, init_busy, core_stall, dbg_req_ready} !==
          {1'b1, 6'(n), 32'h0, 1'b1, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL sweep_cycle_%0d: got wr=%b wa=%0d d=%h busy=%b stall=%b rdy=%b required 1/%0d/0/1/1/0",
                 n, rf_wr, rf_wa, rf_d, init_busy, core_stall, dbg_req_ready, n);
      end
      next_cycle();
    end
    if (full) begin
      @(negedge clk);
      n_cmp++;
      if ({init_busy, core_stall, rf_wr} !== 3'b000) begin
        n_err++; $display("FAIL sweep_exit: got busy=%b stall=%b wr=%b required 0/0/0", init_busy, core_stall, rf_wr);
      end
      next_cycle();
    end
  endtask

  task automatic test_init_sweep();
`ifdef RF_CTRL_INIT_EN
    sweep_check(63, 1'b1);
`else
    @(negedge clk);
    n_cmp++;
    if ({init_busy, core_stall, rf_wr, dbg_req_ready} !== 4'b0001) begin
      n_err++; $display("FAIL no_sweep: got busy=%b stall=%b wr=%b rdy=%b required 0/0/0/1",
                        init_busy, core_stall, rf_wr, dbg_req_ready);
    end
    next_cycle();
`endif
  endtask

  task automatic test_dbg_write_read();
    logic [31:0] exp;
    dbg_req_valid = 1; dbg_req_we = 1; dbg_req_addr = 6'd5; dbg_req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++;
    if ({dbg_req_ready, rf_wr, rf_wa, rf_d} !== {1'b1, 1'b1, 6'd5, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL dbg_wr_accept: got rdy=%b wr=%b wa=%0d d=%h required 1/1/5/deadbeef",
                        dbg_req_ready, rf_wr, rf_wa, rf_d);
    end
    exp_q.push_back(32'h0);
    next_cycle();
    dbg_req_we = 0; dbg_req_wdata = '0;
    @(negedge clk);
    n_cmp++;
    if (dbg_rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      n_err++; $display("FAIL dbg_wr_rsp_valid: got %b required 1", dbg_rsp_valid);
    end else begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (dbg_rsp_rdata !== exp) begin n_err++; $display("FAIL dbg_wr_rsp_data: got %h required %h", dbg_rsp_rdata, exp); end
    end
    n_cmp++;
    if ({dbg_req_ready, rf_ra2} !== {1'b1, 6'd5}) begin
      n_err++; $display("FAIL dbg_rd_accept: got rdy=%b ra2=%0d required 1/5", dbg_req_ready, rf_ra2);
    end
    exp_q.push_back(32'hDEADBEEF);
    next_cycle();
    dbg_req_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (dbg_rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      n_err++; $display("FAIL dbg_rd_rsp_valid: got %b required 1", dbg_rsp_valid);
    end else begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (dbg_rsp_rdata !== exp) begin n_err++; $display("FAIL dbg_rd_rsp_data: got %h required %h", dbg_rsp_rdata, exp); end
    end
    n_cmp++;
    if (dbg_req_ready !== 1'b0) begin n_err++; $display("FAIL rd_wait_ready: got %b required 0", dbg_req_ready); end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (dbg_rsp_valid !== 1'b0 || dbg_rsp_rdata !== 32'h0) begin
      n_err++; $display("FAIL rsp_one_cycle: got %b/%h required 0/0", dbg_rsp_valid, dbg_rsp_rdata);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic [31:0] exp;
    core_wr = 1; core_wa = 6'd7; core_d = 32'h1111;
    dbg_req_valid = 1; dbg_req_we = 1; dbg_req_addr = 6'd9; dbg_req_wdata = 32'hCAFEF00D;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({dbg_req_ready, core_stall, rf_wr, rf_wa, rf_d} !== {1'b0, 1'b0, 1'b1, 6'd7, 32'h1111}) begin
        n_err++; $display("FAIL starve_cycle_%0d: got rdy=%b stall=%b wr=%b wa=%0d d=%h required 0/0/1/7/1111",
                          c, dbg_req_ready, core_stall, rf_wr, rf_wa, rf_d);
      end
      next_cycle();
    end
    @(negedge clk);
    n_cmp++;
    if ({dbg_req_ready, core_stall, rf_wr, rf_wa, rf_d} !== {1'b1, 1'b1, 1'b1, 6'd9, 32'hCAFEF00D}) begin
      n_err++; $display("FAIL starve_stall: got rdy=%b stall=%b wr=%b wa=%0d d=%h required 1/1/1/9/cafef00d",
                        dbg_req_ready, core_stall, rf_wr, rf_wa, rf_d);
    end
    exp_q.push_back(32'h0);
    next_cycle();
    dbg_req_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (dbg_rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      n_err++; $display("FAIL starve_rsp_valid: got %b required 1", dbg_rsp_valid);
    end else begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (dbg_rsp_rdata !== exp) begin n_err++; $display("FAIL starve_rsp_data: got %h required %h", dbg_rsp_rdata, exp); end
    end
    n_cmp++;
    if ({core_stall, rf_wa} !== {1'b0, 6'd7}) begin
      n_err++; $display("FAIL starve_release: got stall=%b wa=%0d required 0/7", core_stall, rf_wa);
    end
    next_cycle();
    core_wr = 0;
    dbg_req_valid = 1; dbg_req_we = 0; dbg_req_addr = 6'd9;
    @(negedge clk);
    exp_q.push_back(32'hCAFEF00D);
    next_cycle();
    dbg_req_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (dbg_rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      n_err++; $display("FAIL starve_readback_valid: got %b required 1", dbg_rsp_valid);
    end else begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (dbg_rsp_rdata !== exp) begin n_err++; $display("FAIL starve_readback_data: got %h required %h", dbg_rsp_rdata, exp); end
    end
    next_cycle();
  endtask

  task automatic test_shared_ports();
    logic [31:0] exp;
    core_wr = 1; core_wa = 6'd12; core_d = 32'h22; core_rd2_en = 0; core_ra1 = 6'd17;
    dbg_req_valid = 1; dbg_req_we = 0; dbg_req_addr = 6'd5;
    @(negedge clk);
    n_cmp++;
    if ({dbg_req_ready, rf_wr, rf_wa, rf_d, rf_ra2, rf_ra1} !==
        {1'b1, 1'b1, 6'd12, 32'h22, 6'd5, 6'd17}) begin
      n_err++; $display("FAIL shared_ports: got rdy=%b wr=%b wa=%0d d=%h ra2=%0d ra1=%0d required 1/1/12/22/5/17",
                        dbg_req_ready, rf_wr, rf_wa, rf_d, rf_ra2, rf_ra1);
    end
    exp_q.push_back(32'hDEADBEEF);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (dbg_rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      n_err++; $display("FAIL shared_rsp_valid: got %b required 1", dbg_rsp_valid);
    end else begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (dbg_rsp_rdata !== exp) begin n_err++; $display("FAIL shared_rsp_data: got %h required %h", dbg_rsp_rdata, exp); end
    end
    next_cycle();
    core_rd2_en = 1; core_ra2 = 6'd3;
    dbg_req_valid = 1; dbg_req_we = 0; dbg_req_addr = 6'd12;
    @(negedge clk);
    n_cmp++;
    if ({dbg_req_ready, rf_ra2} !== {1'b0, 6'd3}) begin
      n_err++; $display("FAIL port2_core_wins: got rdy=%b ra2=%0d required 0/3", dbg_req_ready, rf_ra2);
    end
    next_cycle();
    core_rd2_en = 0;
    @(negedge clk);
    exp_q.push_back(32'h22);
    next_cycle();
    dbg_req_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (dbg_rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      n_err++; $display("FAIL core_write_readback_valid: got %b required 1", dbg_rsp_valid);
    end else begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (dbg_rsp_rdata !== exp) begin n_err++; $display("FAIL core_write_readback_data: got %h required %h", dbg_rsp_rdata, exp); end
    end
    next_cycle();
  endtask

  task automatic test_reset_rd_wait();
    dbg_req_valid = 1; dbg_req_we = 0; dbg_req_addr = 6'd5;
    @(negedge clk);
    n_cmp++;
    if (dbg_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_rd_accept: got %b required 1", dbg_req_ready); end
    next_cycle();
    reset = 1; dbg_req_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (dbg_rsp_valid !== 1'b0 || dbg_rsp_rdata !== 32'h0) begin
      n_err++; $display("FAIL rst_rd_wait_drop: got %b/%h required 0/0", dbg_rsp_valid, dbg_rsp_rdata);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({dbg_rsp_valid, init_busy} !== {1'b0, INIT_EN}) begin
      n_err++; $display("FAIL rst_rd_wait_after: got rsp=%b busy=%b required 0/%b", dbg_rsp_valid, init_busy, INIT_EN);
    end
    next_cycle();
    reset = 0;
    @(negedge clk);
    n_cmp++;
    if (dbg_req_ready !== !INIT_EN) begin
      n_err++; $display("FAIL rst_state: got rdy=%b required %b", dbg_req_ready, !INIT_EN);
    end
  endtask

  task automatic test_sweep_restart();
`ifdef RF_CTRL_INIT_EN
    sweep_check(30, 1'b0);
    reset = 1;
    @(negedge clk);
    n_cmp++;
    if (rf_wr !== 1'b0) begin n_err++; $display("FAIL sweep_reset_wr: got %b required 0", rf_wr); end
    next_cycle();
    reset = 0;
    sweep_check(63, 1'b1);
`else
    next_cycle();
`endif
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_dbg_write_read();
    test_starvation();
    test_shared_ports();
    test_reset_rd_wait();
`ifdef RF_CTRL_INIT_EN
    test_sweep_restart();
`else
    next_cycle();
`endif
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/opicorv32_rf_ctrl.md
OPICORV32_RF_CTRL -- requirements
Module: opicorv32_rf_ctrl

Interface
REQ-001 The block SHALL have these parameters: STARVE_LIMIT, default 8, sets the maximum cycles a pending debug request waits before the core is stalled; DEPTH, default 64, is the register-file entry count (power of two, at most 64).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with these ports: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-003 The block SHALL have these core-side ports: core_wr  in  1  core writeback strobe; core_wa  in  6  writeback address; core_d  in  32  writeback data; core_ra1  in  6; core_ra2  in  6; core_rd2_en  in  1  core uses read port 2 this cycle; core_stall  out  1  core must hold off writes and port-2 reads; init_busy  out  1  init sweep in progress.
REQ-004 The block SHALL have these debug-side ports: dbg_req_valid  in  1; dbg_req_ready  out  1; dbg_req_we  in  1; dbg_req_addr  in  6; dbg_req_wdata  in  32; dbg_rsp_valid  out  1; dbg_rsp_rdata  out  32.
REQ-005 The block SHALL have these register-file-side ports: rf_wr  out  1; rf_wa  out  6; rf_d  out  32; rf_ra1  out  6; rf_ra2  out  6; rf_q2  in  32  read data, valid one cycle after rf_ra2.

Function
REQ-006 The FSM SHALL have the states INIT, IDLE and RD_WAIT.
REQ-007 In INIT, the block SHALL write 0 to address N on cycle N for N = 0..DEPTH-1, hold init_busy=1 and core_stall=1, then go to IDLE.
REQ-008 rf_ra1 SHALL equal core_ra1 in every cycle.
REQ-009 Port sharing in IDLE: the core SHALL drive the write port when core_wr=1 and SHALL drive rf_ra2 when core_rd2_en=1; a debug request SHALL take a port only when the core does not use that port.
REQ-010 dbg_req_ready SHALL be combinational: 1 in IDLE when (dbg_req_we ? !core_wr : !core_rd2_en), or when core_stall=1; 0 in INIT and RD_WAIT.
REQ-011 For an accepted debug write (valid & ready & we), the block SHALL assert rf_wr with dbg_req_addr/dbg_req_wdata in the same cycle, and SHALL give dbg_rsp_valid=1 with dbg_rsp_rdata=0 on the next cycle.
REQ-012 For an accepted debug read, the block SHALL drive rf_ra2=dbg_req_addr, go to RD_WAIT, and on the next cycle give dbg_rsp_valid=1 with dbg_rsp_rdata=rf_q2, then return to IDLE.
REQ-013 dbg_rsp_valid SHALL last exactly one cycle with no backpressure; the response SHALL be 0 in all other cycles.
REQ-014 Simultaneous core_wr and debug write with core_stall=0: the core SHALL win, dbg_req_ready=0, and the debug request SHALL stay pending.
REQ-015 The starvation counter SHALL increment each cycle that dbg_req_valid=1 and dbg_req_ready=0 in IDLE, clear on handshake or when valid drops, and saturate at STARVE_LIMIT.
REQ-016 The block SHALL assert core_stall, registered, for the cycle after the counter reaches STARVE_LIMIT; during that cycle debug SHALL own both the write port and port 2, and core_wr/core_rd2_en SHALL be ignored.
REQ-017 rf_wr SHALL be 0 when no requester writes; rf_wa/rf_d/rf_ra2 SHALL be don't-care when unused.

Reset
REQ-018 During and after reset, all outputs SHALL be 0 except as stated here; the FSM SHALL enter INIT with the sweep counter at 0 (IDLE when the sweep is compiled out).
REQ-019 Reset mid-sweep SHALL restart the sweep at address 0.
REQ-020 Reset in RD_WAIT SHALL drop the response: dbg_rsp_valid=0 on the next cycle.

Configuration
REQ-021 With macro RF_CTRL_INIT_EN defined, INIT and the sweep SHALL be present.
REQ-022 Without RF_CTRL_INIT_EN, reset SHALL go directly to IDLE, init_busy SHALL be tied to 0, and no sweep logic SHALL exist.

Structure
REQ-023 Package opicorv32_rf_pkg SHALL hold RF_AW=6, RF_DW=32 and the FSM state enum.
REQ-024 The sweep counter SHALL be sub-module opicorv32_rf_init_seq, instantiated only under RF_CTRL_INIT_EN.

Verification
REQ-025 The bench SHALL cover these scenarios:
- Reset with RF_CTRL_INIT_EN, DEPTH=64: 64 rf_wr pulses addresses 0..63 with d=0; init_busy falls on cycle 64.
- Debug write addr 5, data 0xDEADBEEF, no core traffic: rf_wr same cycle; rsp_valid next cycle with rdata 0; a following debug read of addr 5 returns 0xDEADBEEF one cycle after accept.
- core_wr held high while a debug write is pending, STARVE_LIMIT=8: ready=0 for 8 cycles; core_stall=1 on cycle 9; debug write lands that cycle.
- core_rd2_en=0 with a debug read and core_wr=1 in the same cycle: both proceed in the same cycle; rf_wa follows core.
- Reset asserted in RD_WAIT: no dbg_rsp_valid; FSM in INIT (or IDLE when compiled out).
- Reset at sweep address 30: the sweep restarts at address 0.
